// File: rtl/rv32i_irq_pkg.sv
// Shared types and helpers for the RV32I interrupt arbiter.
package rv32i_irq_pkg;

  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_PEND   = 2'd1,
    GW_ACTIVE = 2'd2
  } gw_state_e;

  localparam int ID_NONE = 0;

  // Upper bounds used to size the generic priority-extraction helper.
  localparam int MAX_SRC    = 63;
  localparam int PRIO_W_MAX = 8;

  typedef logic [MAX_SRC*PRIO_W_MAX-1:0] prio_vec_t;

  // Extract the w-bit priority of source idx from a packed priority vector.
  // The caller zero-extends its own vector to prio_vec_t and narrows the result.
  function automatic logic [PRIO_W_MAX-1:0] prio_of(input prio_vec_t vec,
                                                   input int idx,
                                                   input int w);
    logic [PRIO_W_MAX-1:0] r;
    r = PRIO_W_MAX'(vec >> (idx * w));
    for (int b = 0; b < PRIO_W_MAX; b++) begin
      if (b >= w) r[b] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32i_irq_arbiter_if.sv
// Claim/complete handshake between the interrupt arbiter and the core.
interface rv32i_irq_arbiter_if #(
  parameter int ID_W   = 6,
  parameter int PRIO_W = 3
);
  logic              irq_req;
  logic [ID_W-1:0]   irq_id;
  logic [PRIO_W-1:0] irq_prio;
  logic              claim_req;
  logic [ID_W-1:0]   claim_id;
  logic              complete_req;
  logic [ID_W-1:0]   complete_id;

  // Core / trap-handler side.
  modport master (
    input  irq_req, irq_id, irq_prio, claim_id,
    output claim_req, complete_req, complete_id
  );

  // Arbiter side.
  modport slave (
    output irq_req, irq_id, irq_prio, claim_id,
    input  claim_req, complete_req, complete_id
  );
endinterface

// File: rtl/rv32i_irq_gateway.sv
// Per-source interrupt gateway: trigger detection, service FSM and one-deep rearm.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// GW_IDLE   | nothing outstanding; a trigger moves to PEND
// GW_PEND   | waiting to be claimed; further triggers change nothing
// GW_ACTIVE | claimed and in service; edges set rearm, level is ignored
module rv32i_irq_gateway
  import rv32i_irq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      irq_src,
  input  logic      edge_mode,
  input  logic      claim_hit,
  input  logic      complete_hit,
  output logic      next_pend,
  output gw_state_e state
);

  gw_state_e state_nxt;
  logic      prev_src;
  logic      rearm;
  logic      rearm_nxt;
  logic      trig;

  // prev_src clears on reset so an edge line already high at release counts as an edge.
  assign trig = edge_mode ? (irq_src & ~prev_src) : irq_src;

  // State, rearm flag and previous line sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GW_IDLE;
      rearm    <= 1'b0;
      prev_src <= 1'b0;
    end else begin
      state    <= state_nxt;
      rearm    <= rearm_nxt;
      prev_src <= irq_src;
    end
  end

  // Next-state and rearm logic.
  always_comb begin
    state_nxt = state;
    rearm_nxt = rearm;
    case (state)
      GW_IDLE: begin
        if (trig) state_nxt = GW_PEND;
      end
      GW_PEND: begin
        if (claim_hit) begin
          state_nxt = GW_ACTIVE;
          // An edge arriving in the claim cycle is held for after completion.
          rearm_nxt = edge_mode & trig;
        end
      end
      GW_ACTIVE: begin
        if (complete_hit) begin
          state_nxt = (rearm || (edge_mode && trig)) ? GW_PEND : GW_IDLE;
          rearm_nxt = 1'b0;
        end else if (edge_mode && trig) begin
          rearm_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = GW_IDLE;
        rearm_nxt = 1'b0;
      end
    endcase
  end

  assign next_pend = (state_nxt == GW_PEND);

endmodule

// File: rtl/rv32i_irq_arbiter.sv
// Interrupt controller top: per-source gateways, priority/threshold arbiter,
// registered request outputs and the claim-ID register.
module rv32i_irq_arbiter
  import rv32i_irq_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        irq_src,
  input  logic [NUM_SRC-1:0]        src_edge,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]         threshold,
  rv32i_irq_arbiter_if.slave        bus
);

  gw_state_e         gw_state [NUM_SRC];
  logic [NUM_SRC-1:0] next_pend;
  logic [NUM_SRC-1:0] claim_hit;
  logic [NUM_SRC-1:0] complete_hit;

  logic              irq_req_q;
  logic [ID_W-1:0]   irq_id_q;
  logic [PRIO_W-1:0] irq_prio_q;
  logic [ID_W-1:0]   claim_id_q;

  logic              win_req;
  logic [ID_W-1:0]   win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [PRIO_W-1:0] best_prio;
  logic [PRIO_W-1:0] cur_prio;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    // Claim targets the registered winner; it is always PEND when published.
    assign claim_hit[g]    = bus.claim_req && irq_req_q &&
                             (irq_id_q == ID_W'(g + 1)) &&
                             (gw_state[g] == GW_PEND);
    // Completes for IDs out of range, ID 0, or non-active sources match nothing.
    assign complete_hit[g] = bus.complete_req &&
                             (bus.complete_id == ID_W'(g + 1)) &&
                             (gw_state[g] == GW_ACTIVE);

    rv32i_irq_gateway u_gw (
      .clk          (clk),
      .rst          (rst),
      .irq_src      (irq_src[g]),
      .edge_mode    (src_edge[g]),
      .claim_hit    (claim_hit[g]),
      .complete_hit (complete_hit[g]),
      .next_pend    (next_pend[g]),
      .state        (gw_state[g])
    );
  end

  // Pick the highest-priority eligible next-state-pending source; strict compare
  // keeps the lowest index on ties and starting from threshold enforces prio > threshold.
  always_comb begin
    best_prio = threshold;
    cur_prio  = '0;
    win_id    = ID_W'(ID_NONE);
    for (int i = 0; i < NUM_SRC; i++) begin
      cur_prio = PRIO_W'(prio_of(prio_vec_t'(src_prio), i, PRIO_W));
      if (next_pend[i] && src_en[i] && (cur_prio > best_prio)) begin
        best_prio = cur_prio;
        win_id    = ID_W'(i + 1);
      end
    end
    win_req  = (win_id != ID_W'(ID_NONE));
    win_prio = win_req ? best_prio : '0;
  end

  // Publish the arbitration result and capture the ID handed out on claim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
      irq_prio_q <= '0;
      claim_id_q <= '0;
    end else begin
      irq_req_q  <= win_req;
      irq_id_q   <= win_id;
      irq_prio_q <= win_prio;
      if (bus.claim_req) claim_id_q <= irq_req_q ? irq_id_q : ID_W'(ID_NONE);
    end
  end

  assign bus.irq_req  = irq_req_q;
  assign bus.irq_id   = irq_id_q;
  assign bus.irq_prio = irq_prio_q;
  assign bus.claim_id = claim_id_q;

endmodule

// File: doc/rv32i_irq_arbiter.md
Name: rv32i_irq_arbiter

Overview:
Parametrised interrupt controller for the RV32I core with per-source gateways, per-source priority, a global priority threshold and a claim/complete handshake.
Each source can be configured as level- or edge-triggered. Edges that arrive while a source is in service are held, not lost.
The block sits between peripheral interrupt lines and the core's external-interrupt input and trap handler.

Parameters:
NUM_SRC, 32, number of interrupt sources (1..63). Source index i has ID i+1; ID 0 means "none".
PRIO_W, 3, priority width. Priority 0 means the source never interrupts.
ID_W, 6, ID width; must satisfy 2**ID_W > NUM_SRC.

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-high)
irq_src  in  NUM_SRC  raw interrupt lines, synchronous to clk
src_edge  in  NUM_SRC  per-source mode: 1 = rising-edge, 0 = level-high
src_en  in  NUM_SRC  per-source enable
src_prio  in  NUM_SRC*PRIO_W  packed priorities; source i occupies bits [i*PRIO_W +: PRIO_W]
threshold  in  PRIO_W  interrupt only if priority > threshold
irq_req  out  1  registered; a source is ready to claim
irq_id  out  ID_W  registered ID of the winning source, 0 if none
irq_prio  out  PRIO_W  registered priority of the winner, 0 if none
claim_req  in  1  single-cycle claim strobe
claim_id  out  ID_W  ID returned by the last claim; held until the next claim
complete_req  in  1  single-cycle completion strobe
complete_id  in  ID_W  ID being completed

Behaviour:
- Reset: clk is the clock; rst is the reset, asynchronous and active-high.
  - All gateways go to IDLE; rearm=0; prev_src=0.
  - irq_req=0, irq_id=0, irq_prio=0, claim_id=0.
  - Any in-service state is discarded. Level sources still high re-pend after reset release.
  - Edge sources that are high at release count as an edge, because prev_src=0.
- Trigger:
  - Level mode: trig = irq_src.
  - Edge mode: trig = irq_src & ~prev_src, where prev_src is the registered previous sample.
- Gateway FSM, one per source:
  - IDLE -> PEND when trig.
  - PEND -> ACTIVE when claim_req and the registered irq_id equals this ID.
  - ACTIVE -> IDLE when complete_req and complete_id equals this ID. If rearm=1, go to PEND instead and clear rearm.
  - In ACTIVE, an edge-mode trig sets rearm. Rearm is one deep: further edges while ACTIVE are merged.
  - Level-mode triggers in ACTIVE are ignored. The source re-pends from IDLE on the following cycle if still high.
  - Trig does not change state while PEND.
- Enable:
  - src_en does not gate capture. A disabled source still goes to PEND but is excluded from arbitration.
  - Re-enabling a pending source makes it eligible for the next arbitration.
- Arbitration (combinational, then registered):
  - Candidates are sources whose next-state is PEND, with src_en=1 and prio > threshold.
  - Highest prio wins. Ties go to the lowest index.
  - Because arbitration uses next-state, a claimed source never appears in irq_id the cycle after its claim.
- Latency: a trig sampled at edge k puts the gateway in PEND, and the arbitration result lands in the output registers at the same edge k.
  - irq_req/irq_id are therefore valid after edge k: one cycle from irq_src rising to irq_req.
- Claim:
  - At a claim_req edge, claim_id <= irq_id (0 if irq_req=0).
  - With irq_req=0 a claim returns 0 and no state changes.
- Complete:
  - complete_id = 0, complete_id > NUM_SRC, or a target not in ACTIVE: ignored silently.
- Simultaneous events:
  - Claim and complete in the same cycle are both applied.
  - A claim together with an edge on the same source gives ACTIVE with rearm=1.
  - A complete together with an edge on the same source gives PEND.
- Priority and threshold changes affect the next cycle's arbitration. A source already ACTIVE is not preempted.

Decomposition:
- Package rv32i_irq_pkg:
  - typedef enum logic [1:0] gw_state_e {GW_IDLE, GW_PEND, GW_ACTIVE}.
  - Constant ID_NONE = 0.
  - Function prio_of(packed vector, index) for extracting a priority.
- Sub-module rv32i_irq_gateway, one per source via generate.
  - Holds prev_src, the FSM and rearm.
  - Inputs: irq_src bit, mode, claim_hit, complete_hit.
  - Outputs: next_pend, state.
- The top level holds the arbiter loop and the output/claim registers.

Test Plan:
- Level source 5 (prio 3, thr 0, en): drive irq_src[5]=1 -> irq_req=1 and irq_id=6 one cycle later. Claim -> claim_id=6 and irq_req=0 next cycle. Complete id 6 with line still high -> irq_req=1 again, irq_id=6.
- Sources 2 and 9 both pending with prio 4 and prio 4 -> irq_id=3 (lowest index). Raise src_prio[9] to 5 -> irq_id=10 the next cycle.
- Edge source 0 (prio 1): pulse, claim (claim_id=1), then 3 more pulses while ACTIVE. Complete 1 -> exactly one re-pend (irq_id=1). Complete again -> irq_req stays 0.
- Threshold 3 with a single pending source at prio 3 -> irq_req=0. Set thr=2 -> irq_req=1. Set src_en=0 -> irq_req=0, and the source is still pending when re-enabled.
- claim_req with irq_req=0 -> claim_id=0, no state change. complete_id=0 and complete_id=40 -> ignored.
- Assert rst mid-service (source 7 ACTIVE, level line high) -> all outputs 0 immediately. After release, irq_req=1 with irq_id=8 within 2 cycles.
